// File: rtl/pixstream_pkg.sv
// Shared types and parameter helpers for the pixel streamer.
package pixstream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  function automatic int ppw(input int dw, input int bpp);
    return dw / bpp;
  endfunction

  // Index needs at least one bit even when a word carries a single pixel.
  function automatic int idx_width(input int dw, input int bpp);
    return (dw / bpp > 1) ? $clog2(dw / bpp) : 1;
  endfunction

  function automatic int byte_inc(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/pixstream_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module pixstream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/pixstream_dma.sv
// Frame-buffer fetcher and pixel serialiser for the VGA path.
// Optional PIXSTREAM_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module pixstream_dma
  import pixstream_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int BPP    = 8,
  parameter int DEPTH  = 8,
  parameter int LOW_WM = DEPTH / 2
) (
  input  logic           i_wb_clk,
  input  logic           i_wb_rst,
  input  logic [AW-1:0]  i_pix_addr_base,
  input  logic           i_pix_addr_reset,
  input  logic           i_pix_en,
  input  logic           i_pix_gate,
  output logic [BPP-1:0] o_pix_dat,
  output logic           o_pix_valid,
  output logic           o_underrun,
`ifdef PIXSTREAM_UNDERRUN_CNT_EN
  output logic [15:0]    o_underrun_cnt,
`endif
  output logic [AW-1:0]  o_wb_addr,
  output logic           o_wb_cyc,
  output logic           o_wb_stb,
  input  logic           i_wb_ack,
  input  logic [DW-1:0]  i_wb_dat
);

  localparam int PPW = ppw(DW, BPP);
  localparam int IW  = idx_width(DW, BPP);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PPW - 1);
  localparam logic [CW-1:0] LOW_WM_C = CW'(LOW_WM);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [AW-1:0] ADDR_INC = AW'(byte_inc(DW));

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BPP-1:0]  pix_dat_q, pix_dat_d;
  logic            pix_valid_q, pix_valid_d;
  logic            underrun_q, underrun_d;

  logic            demand, push, pop, empty;
  logic [CW-1:0]   count, post_count;
  logic [DW-1:0]   rdata, shifted;

  // A frame restart swallows any ack or pixel demand in the same cycle.
  assign demand     = i_pix_en & i_pix_gate & ~i_pix_addr_reset;
  assign push       = (state_q == FETCH) & i_wb_ack & ~i_pix_addr_reset;
  assign pop        = demand & ~empty & (idx_q == LAST_IDX);
  assign post_count = count + CW'(push) - CW'(pop);
  assign shifted    = rdata << (int'(idx_q) * BPP);

  pixstream_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_wb_clk),
    .rst   (i_wb_rst),
    .flush (i_pix_addr_reset),
    .push  (push),
    .pop   (pop),
    .wdata (i_wb_dat),
    .rdata (rdata),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    pix_dat_d   = pix_dat_q;
    pix_valid_d = 1'b0;
    underrun_d  = 1'b0;
    if (i_pix_addr_reset) begin
      state_d = IDLE;
      addr_d  = i_pix_addr_base;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE:    if (count <= LOW_WM_C) state_d = FETCH;
        FETCH:   if (push && post_count == FULL_C) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (push) addr_d = addr_q + ADDR_INC;
      if (demand) begin
        if (empty) begin
          pix_dat_d  = '0;
          underrun_d = 1'b1;
        end else begin
          pix_dat_d   = shifted[DW-1 -: BPP];
          pix_valid_d = 1'b1;
          idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      idx_q       <= '0;
      pix_dat_q   <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      pix_dat_q   <= pix_dat_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef PIXSTREAM_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (i_pix_addr_reset)                     ucnt_d = '0;
    else if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign o_underrun_cnt = ucnt_q;
`endif

  assign o_pix_dat   = pix_dat_q;
  assign o_pix_valid = pix_valid_q;
  assign o_underrun  = underrun_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_cyc    = (state_q == FETCH);
  assign o_wb_stb    = (state_q == FETCH);

endmodule

// File: tb/tb_pixstream_dma.sv
// Directed bench for pixstream_dma: 8-bpp instance with a wait-state slave and
// a 4-bpp instance with a zero-wait slave.
module tb_pixstream_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bpp instance signals
  logic [31:0] base;
  logic        addr_reset, pix_en, pix_gate;
  logic [7:0]  pix_dat;
  logic        pix_valid, underrun;
  logic [31:0] wb_addr, wb_dat;
  logic        cyc, stb;
  logic        ack;
  logic        stall;
  int          waits, wcnt;

  // 4-bpp instance signals
  logic        addr_reset4, pix_en4, gate4;
  logic [3:0]  pix_dat4;
  logic        pix_valid4, underrun4;
  logic [31:0] wb_addr4;
  logic        cyc4, stb4;

`ifdef PIXSTREAM_UNDERRUN_CNT_EN
  logic [15:0] ucnt8, ucnt4;
`endif

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hAABBCCDD : (a ^ 32'h5A5A_0000);
  endfunction

  assign wb_dat = mem_word(wb_addr);

  pixstream_dma #(.DW(32), .AW(32), .BPP(8), .DEPTH(8), .LOW_WM(4)) u_dut8 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_pix_addr_base(base),
    .i_pix_addr_reset(addr_reset), .i_pix_en(pix_en), .i_pix_gate(pix_gate),
    .o_pix_dat(pix_dat), .o_pix_valid(pix_valid), .o_underrun(underrun),
`ifdef PIXSTREAM_UNDERRUN_CNT_EN
    .o_underrun_cnt(ucnt8),
`endif
    .o_wb_addr(wb_addr), .o_wb_cyc(cyc), .o_wb_stb(stb),
    .i_wb_ack(ack), .i_wb_dat(wb_dat)
  );

  pixstream_dma #(.DW(32), .AW(32), .BPP(4), .DEPTH(8), .LOW_WM(4)) u_dut4 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_pix_addr_base(base),
    .i_pix_addr_reset(addr_reset4), .i_pix_en(pix_en4), .i_pix_gate(gate4),
    .o_pix_dat(pix_dat4), .o_pix_valid(pix_valid4), .o_underrun(underrun4),
`ifdef PIXSTREAM_UNDERRUN_CNT_EN
    .o_underrun_cnt(ucnt4),
`endif
    .o_wb_addr(wb_addr4), .o_wb_cyc(cyc4), .o_wb_stb(stb4),
    .i_wb_ack(cyc4), .i_wb_dat(32'h12345678)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave: ack after `waits` idle strobe cycles, one-cycle ack, never while stalled.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (ack) begin
      ack <= 1'b0;
    end else if (cyc && !stall) begin
      if (wcnt >= waits) begin
        ack  <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Monitor: pixel scoreboard, fetch log, refill-watermark and overflow checks.
  logic [31:0] fetch_q[$];
  logic [31:0] word_q[$];
  int          exp_idx = 0;
  int          underrun_seen = 0;
  logic        prev_block = 1'b1;
  logic        prev_cyc = 1'b0;
  logic [3:0]  prev_count = '0;

  always @(negedge clk) begin
    if (rst) begin
      word_q.delete();
      exp_idx    = 0;
      prev_block = 1'b1;
    end else begin
      if (pix_valid) begin
        check("sb_nonempty", word_q.size() != 0, 1);
        if (word_q.size() != 0) begin
          check("sb_pix", pix_dat, (word_q[0] >> ((3 - exp_idx) * 8)) & 32'hFF);
          exp_idx++;
          if (exp_idx == 4) begin
            exp_idx = 0;
            void'(word_q.pop_front());
          end
        end
      end
      if (underrun) underrun_seen++;
      if (!prev_block && !prev_cyc) check("refill_wm", cyc, prev_count <= 4);
      if (cyc && ack && !addr_reset) begin
        check("no_ovf", u_dut8.u_fifo.count_q != 4'd8, 1);
        fetch_q.push_back(wb_addr);
        word_q.push_back(mem_word(wb_addr));
      end
      if (addr_reset) begin
        word_q.delete();
        exp_idx = 0;
      end
      prev_block = addr_reset;
      prev_cyc   = cyc;
      prev_count = u_dut8.u_fifo.count_q;
    end
  end

  logic [7:0]  exp8 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [31:0] w;
  int          n, fsz;

  initial begin
    base = '0; addr_reset = 1'b1; pix_en = 1'b0; pix_gate = 1'b0;
    stall = 1'b0; waits = 0;
    addr_reset4 = 1'b1; pix_en4 = 1'b0; gate4 = 1'b1;
    #2 rst = 1'b1;
    repeat (2) tick();
    check("rst_dat", pix_dat, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_addr", wb_addr, 0);
    check("rst_count", u_dut8.u_fifo.count_q, 0);

    // Frame restart at 0x1000, zero-wait slave, fill to DEPTH
    rst = 1'b0; base = 32'h1000;
    tick();
    addr_reset = 1'b0; addr_reset4 = 1'b0;
    check("restart_addr", wb_addr, 32'h1000);
    check("restart_idle", cyc, 0);
    tick();
    check("fetch_cyc", cyc, 1);
    check("fetch_stb", stb, 1);
    for (n = 0; n < 100 && cyc; n++) tick();
    check("fill_done", cyc, 0);
    check("fill_count", u_dut8.u_fifo.count_q, 8);
    check("fill_nfetch", fetch_q.size(), 8);
    for (int i = 0; i < 8; i++) check("fill_addr", fetch_q[i], 32'h1000 + 4 * i);

    // 8-bpp slices MSB-first, pop with the last slice
    pix_gate = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_en = 1'b1;
      tick();
      check("pix8_dat", pix_dat, exp8[i]);
      check("pix8_valid", pix_valid, 1);
      check("pix8_count", u_dut8.u_fifo.count_q, (i == 3) ? 7 : 8);
    end
    pix_en = 1'b0;
    tick();
    check("ungated_valid", pix_valid, 0);
    check("ungated_hold", pix_dat, 8'hDD);
    check("no_refill_at7", cyc, 0);

    // 4-bpp instance: 0x12345678 -> 1..8, one pop after the eighth
    for (int i = 0; i < 8; i++) begin
      pix_en4 = 1'b1;
      tick();
      check("pix4_dat", pix_dat4, i + 1);
      check("pix4_valid", pix_valid4, 1);
      check("pix4_count", u_dut4.u_fifo.count_q, (i == 7) ? 7 : 8);
    end
    pix_en4 = 1'b0;

    // Slow slave with continuous half-rate pixel demand: no underrun
    waits = 3;
    underrun_seen = 0;
    fsz = fetch_q.size();
    for (int c = 0; c < 200; c++) begin
      pix_en = (c % 2 == 0);
      tick();
    end
    pix_en = 1'b0;
    check("slow_no_underrun", underrun_seen, 0);
    check("slow_fetched", fetch_q.size() > fsz, 1);

    // Stalled slave: drain, then one underrun pulse per demand
    waits = 0; stall = 1'b1; pix_en = 1'b1;
    for (n = 0; n < 100 && !underrun; n++) tick();
    check("stall_underrun", underrun, 1);
    check("stall_count", u_dut8.u_fifo.count_q, 0);
    for (int i = 0; i < 3; i++) begin
      pix_en = 1'b0;
      tick();
      check("ur_gap", underrun, 0);
      pix_en = 1'b1;
      tick();
      check("ur_pulse", underrun, 1);
      check("ur_dat", pix_dat, 0);
      check("ur_valid", pix_valid, 0);
    end
    pix_en = 1'b0;
    check("stall_cyc", cyc, 1);
`ifdef PIXSTREAM_UNDERRUN_CNT_EN
    check("ucnt", ucnt8, 4);
`endif
    fsz = fetch_q.size();
    stall = 1'b0;
    tick();
    for (n = 0; n < 100 && cyc; n++) tick();
    check("recover_done", cyc, 0);
    check("recover_count", u_dut8.u_fifo.count_q, 8);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    w = mem_word(fetch_q[fsz]);
    check("resume_pix", pix_dat, w[31:24]);

    // Frame restart coinciding with an ack mid-FETCH
    pix_en = 1'b1;
    for (n = 0; n < 60 && !cyc; n++) tick();
    pix_en = 1'b0;
    for (n = 0; n < 60 && !ack; n++) tick();
    check("mid_ack", ack, 1);
    fetch_q.delete();
    addr_reset = 1'b1; base = 32'h3000; pix_en = 1'b1;
    tick();
    addr_reset = 1'b0; pix_en = 1'b0;
    check("rr_addr", wb_addr, 32'h3000);
    check("rr_idle", cyc, 0);
    check("rr_flush", u_dut8.u_fifo.count_q, 0);
    check("rr_nopush", fetch_q.size(), 0);
    check("rr_pix_ignored", pix_valid, 0);
    check("rr_no_underrun", underrun, 0);
`ifdef PIXSTREAM_UNDERRUN_CNT_EN
    check("ucnt_clr", ucnt8, 0);
`endif
    tick();
    check("rr_cyc", cyc, 1);
    for (n = 0; n < 60 && fetch_q.size() < 2; n++) tick();
    check("rr_fetch0", fetch_q[0], 32'h3000);
    check("rr_fetch1", fetch_q[1], 32'h3004);

    // Address wrap at the top of the space
    fetch_q.delete();
    addr_reset = 1'b1; base = 32'hFFFF_FFFC;
    tick();
    addr_reset = 1'b0;
    for (n = 0; n < 60 && fetch_q.size() < 2; n++) tick();
    check("wrap_fetch0", fetch_q[0], 32'hFFFF_FFFC);
    check("wrap_fetch1", fetch_q[1], 32'h0000_0000);
    for (n = 0; n < 100 && cyc; n++) tick();
    check("wrap_fill_done", cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixstream_dma.md
# pixstream_dma

Parametrised pixel streamer for the VGA path: fetches frame-buffer words over a reduced Wishbone master port into an internal FIFO and serialises them into pixels of configurable depth. It runs in a single clock domain with a pixel-enable strobe. It supports selectable bits-per-pixel, FIFO depth and refill watermark, and reports underruns. It sits between the frame-buffer memory bus and the VGA timing/colour stage.

## Interface
- DW, 32: Wishbone data width in bits; power of two, ≥ 8.
- AW, 32: address width in bits.
- BPP, 8: bits per pixel; one of 1, 2, 4, 8, 16; must divide DW.
- DEPTH, 8: FIFO depth in words; power of two, ≥ 2.
- LOW_WM, DEPTH/2: refill starts when FIFO count ≤ LOW_WM; range 0..DEPTH-1.
- i_wb_clk  in  1  sole clock.
- i_wb_rst  in  1  reset, asynchronous, active-high.
- i_pix_addr_base  in  AW  frame start byte address.
- i_pix_addr_reset  in  1  frame restart pulse.
- i_pix_en  in  1  pixel-clock enable, one pulse per pixel slot.
- i_pix_gate  in  1  visible area; pixels are consumed only when i_pix_en & i_pix_gate.
- o_pix_dat  out  BPP  pixel value.
- o_pix_valid  out  1  o_pix_dat holds a real pixel.
- o_underrun  out  1  one-cycle pulse: a pixel was demanded while the FIFO was empty.
- o_wb_addr  out  AW  byte address.
- o_wb_cyc / o_wb_stb  out  1  bus cycle / strobe; always equal.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_dat  in  DW  read data.

## Operation
- Reset values: o_pix_dat = 0, o_pix_valid = 0, o_underrun = 0, o_wb_cyc/stb = 0, o_wb_addr = 0, FIFO empty, pixel index = 0, state IDLE.
- FSM states:
  - IDLE → FETCH when count ≤ LOW_WM and i_pix_addr_reset = 0.
  - FETCH → IDLE on the ack that makes the post-update count equal DEPTH.
  - FETCH → IDLE on i_pix_addr_reset.
  - Post-update count = count + push − pop.
- Bus:
  - cyc/stb are registered and equal (state == FETCH).
  - Each ack pushes i_wb_dat into the FIFO and advances o_wb_addr by DW/8, wrapping modulo 2^AW.
  - Reads are single-outstanding, classic cycle; one word per ack.
- Pixel serialisation:
  - PPW = DW/BPP pixels per word, MSB-first: index 0 = bits [DW-1:DW-BPP].
  - On i_pix_en & i_pix_gate with the FIFO non-empty: output the slice at the current index and increment the index; at index PPW-1, pop the FIFO and wrap the index to 0.
  - On i_pix_en & i_pix_gate with the FIFO empty: o_pix_dat = 0, o_pix_valid = 0, o_underrun pulses, index unchanged.
  - When not gated: o_pix_valid = 0, o_pix_dat holds its value.
- i_pix_addr_reset has priority over everything:
  - Flushes the FIFO, index = 0, o_wb_addr = i_pix_addr_base, FSM = IDLE, cyc drops next cycle.
  - An ack in the same cycle is discarded: no push, no address increment.
  - A pixel demand in the same cycle is ignored.
- Simultaneous push and pop: count unchanged, both take effect.
- FIFO overflow is impossible by construction. A push never occurs at count = DEPTH; the bench asserts this.

## Timing
- o_pix_dat, o_pix_valid and o_underrun are registered one cycle after the qualifying i_pix_en.
- Refill request: cyc rises one cycle after the count reaches ≤ LOW_WM.
- First pixel after a frame restart requires at least one completed ack. Software/VGA timing must leave ≥ (bus latency + 2) cycles between i_pix_addr_reset and the first gated i_pix_en.
- Pop happens in the same cycle as the last-slice output register update; the next word is visible on the next demand.

## Configuration
- PIXSTREAM_UNDERRUN_CNT_EN:
  - Defined: adds output o_underrun_cnt [15:0]. It increments (saturating at 0xFFFF) on each o_underrun pulse, clears on i_wb_rst and on i_pix_addr_reset, and resets to 0.
  - Undefined: the port and counter are absent; o_underrun still exists.

## Structure
- pixstream_pkg: FSM state enum (IDLE, FETCH) and localparam helpers (PPW, index width, byte increment DW/8).
- Sub-module pixstream_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH; flush input; count output of width $clog2(DEPTH)+1.
  - First-word-fall-through read data.
  - Asynchronous reset.

## Test plan
- Reset, then frame restart with base 0x1000, DW=32, BPP=8, slave acks with 0 wait → fetches 0x1000, 0x1004, … until count = 8; cyc drops. Gated pixels of word 0xAABBCCDD emerge as AA, BB, CC, DD.
- BPP=4, word 0x12345678 → eight pixels 1..8, with one pop after the 8th.
- Continuous gating with a slow slave (3 wait states) → no underrun. Refill restarts exactly when count ≤ 4.
- Slave stalls ack indefinitely while gated pixels drain → o_underrun pulses once per demand, o_pix_dat = 0, index frozen. With PIXSTREAM_UNDERRUN_CNT_EN defined, the counter counts the pulses.
- i_pix_addr_reset in the same cycle as an ack mid-FETCH → no push, address = new base, FIFO empty, IDLE, then refetch from the base.
- Base 0xFFFFFFFC, AW=32 → second fetch address is 0x00000000.
